// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared cause codes and sequencer state encoding
package exc_pkg;

    localparam logic [1:0] EC_OPCODE = 2'b00;
    localparam logic [1:0] EC_OVF    = 2'b01;
    localparam logic [1:0] EC_DIV0   = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        FETCH   = 2'b10,
        LOAD    = 2'b11
    } state_t;

endpackage

// File: rtl/exc_priority_enc.sv
// rtl/exc_priority_enc.sv - fixed-priority encoder of exception causes
module exc_priority_enc
    import exc_pkg::*;
(
    input  logic [2:0] cause,
    output logic       valid,
    output logic [1:0] code
);

    // cause[0]=opcode, cause[1]=ovf, cause[2]=div0; lowest index wins
    always_comb begin
        valid = |cause;
        code  = EC_OPCODE;
        if (cause[0]) begin
            code = EC_OPCODE;
        end else if (cause[1]) begin
            code = EC_OVF;
        end else if (cause[2]) begin
            code = EC_DIV0;
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - multicycle exception entry: capture cause, write EPC, fetch vector, load PC
module exception_sequencer
    import exc_pkg::*;
#(
    parameter int MEM_LAT   = 2,
    parameter int PC_OFFSET = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic [31:0] new_pc,
    input  logic [31:0] old_pc,
    input  logic [31:0] mem_data_in,
    output logic [1:0]  ec_control,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        epc_write,
    output logic [31:0] epc_data,
    output logic        pc_write,
    output logic [31:0] pc_next,
    output logic        exc_busy,
    output logic        exc_lost
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic          cause_valid;
    logic [1:0]    cause_code;
    state_t        state;
    logic [CW-1:0] cnt;

    // Handler addresses live in one byte; the upper data bits carry nothing.
    logic unused_data_hi;
    assign unused_data_hi = ^mem_data_in[31:8];

    exc_priority_enc u_enc (
        .cause ({exc_div0, exc_ovf, exc_opcode}),
        .valid (cause_valid),
        .code  (cause_code)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ec_control <= 2'b00;
            mem_addr   <= '0;
            mem_read   <= 1'b0;
            epc_write  <= 1'b0;
            epc_data   <= '0;
            pc_write   <= 1'b0;
            pc_next    <= '0;
            exc_busy   <= 1'b0;
            exc_lost   <= 1'b0;
        end else begin
            epc_write <= 1'b0;
            pc_write  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cause_valid) begin
                        ec_control <= cause_code;
                        epc_write  <= 1'b1;
                        epc_data   <= old_pc - 32'(PC_OFFSET);
                        exc_busy   <= 1'b1;
                        state      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    mem_read <= 1'b1;
                    mem_addr <= new_pc;
                    cnt      <= CW'(MEM_LAT - 1);
                    state    <= FETCH;
                end
                FETCH: begin
                    if (cnt == '0) begin
                        mem_read <= 1'b0;
                        pc_write <= 1'b1;
                        pc_next  <= {24'b0, mem_data_in[7:0]};
                        state    <= LOAD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                LOAD: begin
                    exc_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Any cause arriving outside IDLE (LOAD included) is lost, not queued.
            if (cause_valid && (state != IDLE)) begin
                exc_lost <= 1'b1;
            end
        end
    end

endmodule
